// File: rtl/vend_dispense_sched.sv
// vend_dispense_sched
//   Shares a single chocolate dispenser between NPORT coin kiosks. Each port
//   accumulates credit from 1- and 2-rupee coin pulses. Once a port holds at
//   least PRICE, a round-robin arbiter grants it the dispenser over a
//   disp_req/disp_ack handshake. It then pulses the product and change
//   indications back to that port.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   one_in, two_in     per-port coin pulses (one cycle per coin)
//   disp_req/disp_port request to the dispenser and the granted port index
//   disp_ack           dispenser finished (only honoured while granting)
//   choco_out          one-cycle product pulse on the served port
//   chng_out/chng_amt  one-cycle change pulse and amount (credit - PRICE)
//   coin_rej           one-cycle pulse, a cycle after a refused coin
//   fault              one-cycle pulse when a grant times out
//   busy               FSM is not idle
module vend_dispense_sched #(
    parameter int NPORT      = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 6,
    parameter int CW         = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORT-1:0]         one_in,
    input  logic [NPORT-1:0]         two_in,
    output logic                     disp_req,
    output logic [$clog2(NPORT)-1:0] disp_port,
    input  logic                     disp_ack,
    output logic [NPORT-1:0]         choco_out,
    output logic [NPORT-1:0]         chng_out,
    output logic [CW-1:0]            chng_amt,
    output logic [NPORT-1:0]         coin_rej,
    output logic                     fault,
    output logic                     busy
);

    localparam int PW = $clog2(NPORT);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [NPORT-1:0][CW-1:0] credit_q, credit_d;
    logic [NPORT-1:0]         coin_rej_q, coin_rej_d;
    logic [PW-1:0]            win_q, win_d;
    logic [PW-1:0]            rr_q, rr_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     fault_q, fault_d;

    logic [NPORT-1:0]         ready;
    logic                     arb_found;
    logic [PW-1:0]            arb_idx;
    logic [PW:0]              cand;
    logic [PW-1:0]            win_inc;
    logic                     tmo_hit;

    // ------------------------------------------------------------------
    // Per-port coin intake and credit bookkeeping
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [CW:0]   add;
        logic [CW:0]   sum;
        logic [CW-1:0] cred_nxt;
        logic          granted;
        logic          both;
        logic          over;

        always_comb begin
            add = '0;
            if (one_in[p] && !two_in[p]) begin
                add = (CW+1)'(1);
            end else if (two_in[p] && !one_in[p]) begin
                add = (CW+1)'(2);
            end
        end

        // One extra bit so the ceiling check sees the true sum.
        assign sum     = {1'b0, credit_q[p]} + add;
        assign granted = (state_q != IDLE) && (win_q == PW'(p));
        assign both    = one_in[p] & two_in[p];
        assign over    = sum > (CW+1)'(MAX_CREDIT);

        assign coin_rej_d[p] = both | ((add != '0) & (granted | over));
        assign ready[p]      = credit_q[p] >= CW'(PRICE);

        always_comb begin
            cred_nxt = credit_q[p];
            if (state_q == DONE && win_q == PW'(p)) begin
                cred_nxt = '0;
            end else if (add != '0 && !granted && !over) begin
                cred_nxt = sum[CW-1:0];
            end
        end

        assign credit_d[p] = cred_nxt;
    end

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_q; the first ready port wins
    // ------------------------------------------------------------------
    always_comb begin : arb_p
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NPORT; i++) begin
            cand = {1'b0, rr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NPORT)) begin
                cand = cand - (PW+1)'(NPORT);
            end
            if (!arb_found && ready[cand[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[PW-1:0];
            end
        end
    end

    assign win_inc = (win_q == PW'(NPORT - 1)) ? '0 : win_q + PW'(1);
    // The grant lasts exactly TIMEOUT cycles when no ack arrives.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin : nxt_p
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found) state_d = GRANT;
            GRANT: begin
                if (disp_ack) begin
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs (decoded from state so reset drops them immediately)
    always_comb begin : out_p
        disp_req  = 1'b0;
        choco_out = '0;
        chng_out  = '0;
        chng_amt  = '0;
        case (state_q)
            GRANT: disp_req = 1'b1;
            DONE: begin
                choco_out[win_q] = 1'b1;
                if (credit_q[win_q] > CW'(PRICE)) begin
                    chng_out[win_q] = 1'b1;
                    chng_amt        = credit_q[win_q] - CW'(PRICE);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Winner, pointer, timeout and fault bookkeeping
    // ------------------------------------------------------------------
    always_comb begin : dp_p
        win_d   = win_q;
        rr_d    = rr_q;
        tmo_d   = tmo_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    win_d = arb_idx;
                    tmo_d = '0;
                end
            end
            GRANT: begin
                if (!disp_ack) begin
                    if (tmo_hit) begin
                        // Abandon the grant; the port keeps its credit.
                        fault_d = 1'b1;
                        rr_d    = win_inc;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            DONE: begin
                rr_d  = win_inc;
                tmo_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q   <= '0;
            coin_rej_q <= '0;
            win_q      <= '0;
            rr_q       <= '0;
            tmo_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
            win_q      <= win_d;
            rr_q       <= rr_d;
            tmo_q      <= tmo_d;
            fault_q    <= fault_d;
        end
    end

    assign disp_port = win_q;
    assign coin_rej  = coin_rej_q;
    assign fault     = fault_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Directed bench for vend_dispense_sched (4 ports, price 3, ceiling 6).
// A table of per-cycle vectors covers the arbitration, change and coin
// refusal behaviour. Hand-written sequences cover timeout and reset.
module tb_vend_dispense_sched;

    localparam int NPORT      = 4;
    localparam int PRICE      = 3;
    localparam int MAX_CREDIT = 6;
    localparam int CW         = 3;
    localparam int TIMEOUT    = 255;

    localparam logic [3:0] N  = 4'h0;
    localparam logic [3:0] P0 = 4'h1;
    localparam logic [3:0] P1 = 4'h2;
    localparam logic [3:0] P2 = 4'h4;
    localparam logic [3:0] P3 = 4'h8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NPORT-1:0] one_in = '0;
    logic [NPORT-1:0] two_in = '0;
    logic             disp_ack = 1'b0;
    logic             disp_req;
    logic [1:0]       disp_port;
    logic [NPORT-1:0] choco_out;
    logic [NPORT-1:0] chng_out;
    logic [CW-1:0]    chng_amt;
    logic [NPORT-1:0] coin_rej;
    logic             fault;
    logic             busy;

    int checks = 0;
    int errors = 0;

    vend_dispense_sched #(
        .NPORT(NPORT), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT),
        .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .one_in(one_in), .two_in(two_in),
        .disp_req(disp_req), .disp_port(disp_port), .disp_ack(disp_ack),
        .choco_out(choco_out), .chng_out(chng_out), .chng_amt(chng_amt),
        .coin_rej(coin_rej), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] one;
        logic [3:0] two;
        logic       ack;
        logic       req;
        logic [1:0] port;
        logic [3:0] choco;
        logic [3:0] chng;
        logic [2:0] amt;
        logic [3:0] rej;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t idl(input logic [3:0] one, input logic [3:0] two,
                                 input logic ack, input logic [3:0] rej);
        vec_t v;
        v.one = one; v.two = two; v.ack = ack; v.req = 1'b0; v.port = 2'd0;
        v.choco = N; v.chng = N; v.amt = 3'd0; v.rej = rej; v.busy = 1'b0;
        return v;
    endfunction

    function automatic vec_t grt(input logic [3:0] one, input logic [3:0] two,
                                 input logic [1:0] port, input logic [3:0] rej);
        vec_t v;
        v.one = one; v.two = two; v.ack = 1'b0; v.req = 1'b1; v.port = port;
        v.choco = N; v.chng = N; v.amt = 3'd0; v.rej = rej; v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t don(input logic [3:0] choco, input logic [3:0] chng,
                                 input logic [2:0] amt);
        vec_t v;
        v.one = N; v.two = N; v.ack = 1'b1; v.req = 1'b0; v.port = 2'd0;
        v.choco = choco; v.chng = chng; v.amt = amt; v.rej = N; v.busy = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Packed order: req, choco, chng, amt, rej, fault, busy
    task automatic chk_out(input string name, input logic req, input logic [3:0] choco,
                           input logic [3:0] chng, input logic [2:0] amt,
                           input logic [3:0] rej, input logic flt, input logic bsy);
        chk(name, 32'({disp_req, choco_out, chng_out, chng_amt, coin_rej, fault, busy}),
            32'({req, choco, chng, amt, rej, flt, bsy}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] one, input logic [3:0] two, input logic ack);
        one_in = one; two_in = two; disp_ack = ack;
    endtask

    initial begin : main
        int cnt;

        // Ports 1 and 3 ready together, pointer 0: port 1 then port 3
        vq.push_back(idl(N, P1|P3, 1'b0, N));
        vq.push_back(idl(P1|P3, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd1, N));
        vq.push_back(don(P1, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd3, N));
        vq.push_back(don(P3, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        // Pointer wrapped to 0: ports 0 and 3 ready, port 0 first
        vq.push_back(idl(N, P0|P3, 1'b0, N));
        vq.push_back(idl(P0|P3, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd0, N));
        vq.push_back(don(P0, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd3, N));
        vq.push_back(don(P3, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        // Port 1 alone (1 then 2) moves the pointer to 2
        vq.push_back(idl(P1, N, 1'b0, N));
        vq.push_back(idl(N, P1, 1'b0, N));
        vq.push_back(grt(N, N, 2'd1, N));
        vq.push_back(don(P1, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        // Pointer 2: ports 1 and 3 ready, port 3 first
        vq.push_back(idl(N, P1|P3, 1'b0, N));
        vq.push_back(idl(P1|P3, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd3, N));
        vq.push_back(don(P3, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd1, N));
        vq.push_back(don(P1, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        // Port 2 two twice: credit 4, change 1; ack in DONE ignored
        vq.push_back(idl(N, P2, 1'b0, N));
        vq.push_back(idl(N, P2, 1'b0, N));
        vq.push_back(grt(N, N, 2'd2, N));
        vq.push_back(don(P2, P2, 3'd1));
        vq.push_back(idl(N, N, 1'b1, N));
        // Port 0: two then one, coin during grant refused, ack after 3 req cycles
        vq.push_back(idl(N, P0, 1'b0, N));
        vq.push_back(idl(P0, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd0, N));
        vq.push_back(grt(P0, N, 2'd0, P0));
        vq.push_back(grt(N, N, 2'd0, N));
        vq.push_back(don(P0, N, 3'd0));
        vq.push_back(idl(P0, N, 1'b0, P0));
        // Credit was cleared: 2 rupees is not enough; ack in IDLE ignored
        vq.push_back(idl(N, P0, 1'b0, N));
        vq.push_back(idl(N, N, 1'b1, N));
        vq.push_back(idl(P0, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd0, N));
        vq.push_back(don(P0, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        // Port 0 fills to 6 while port 1 holds the grant; more coins refused
        vq.push_back(idl(N, P1, 1'b0, N));
        vq.push_back(idl(P1, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd1, N));
        vq.push_back(grt(N, P0, 2'd1, N));
        vq.push_back(grt(N, P0, 2'd1, N));
        vq.push_back(grt(N, P0, 2'd1, N));
        vq.push_back(grt(P0, N, 2'd1, P0));
        vq.push_back(grt(N, P0, 2'd1, P0));
        vq.push_back(don(P1, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd0, N));
        vq.push_back(don(P0, P0, 3'd3));
        vq.push_back(idl(N, N, 1'b0, N));
        // Both coins together on port 1: refused, credit untouched
        vq.push_back(idl(P1, P1, 1'b0, P1));
        vq.push_back(idl(N, P1, 1'b0, N));
        vq.push_back(idl(N, N, 1'b0, N));
        vq.push_back(idl(P1, N, 1'b0, N));
        vq.push_back(grt(N, N, 2'd1, N));
        vq.push_back(don(P1, N, 3'd0));
        vq.push_back(idl(N, N, 1'b0, N));

        // Reset state
        reset = 1'b0;
        repeat (2) tick();
        chk_out("reset_outputs", 1'b0, N, N, 3'd0, N, 1'b0, 1'b0);
        chk("reset_port", 32'(disp_port), 32'd0);
        reset = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].one, vq[i].two, vq[i].ack);
            tick();
            chk_out($sformatf("vec%0d", i), vq[i].req, vq[i].choco, vq[i].chng,
                    vq[i].amt, vq[i].rej, 1'b0, vq[i].busy);
            if (vq[i].req) chk($sformatf("vec%0d_port", i), 32'(disp_port), 32'(vq[i].port));
        end
        drive(N, N, 1'b0);

        // Timeout: port 1 granted with no ack, port 2 becomes ready meanwhile
        drive(N, P1, 1'b0); tick();
        drive(P1, N, 1'b0); tick();
        drive(N, N, 1'b0);  tick();
        chk_out("tmo_grant", 1'b1, N, N, 3'd0, N, 1'b0, 1'b1);
        chk("tmo_grant_port", 32'(disp_port), 32'd1);
        cnt = 1;
        for (int it = 0; it < 400; it++) begin
            if (it == 0)      drive(N, P2, 1'b0);
            else if (it == 1) drive(P2, N, 1'b0);
            else              drive(N, N, 1'b0);
            tick();
            if (!disp_req) break;
            cnt++;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'(TIMEOUT));
        chk_out("tmo_fault", 1'b0, N, N, 3'd0, N, 1'b1, 1'b0);
        tick();
        chk_out("tmo_next_grant", 1'b1, N, N, 3'd0, N, 1'b0, 1'b1);
        chk("tmo_next_port", 32'(disp_port), 32'd2);
        drive(N, N, 1'b1); tick();
        chk_out("tmo_p2_done", 1'b0, P2, N, 3'd0, N, 1'b0, 1'b1);
        drive(N, N, 1'b0); tick();
        tick();
        chk_out("tmo_p1_regrant", 1'b1, N, N, 3'd0, N, 1'b0, 1'b1);
        chk("tmo_p1_port", 32'(disp_port), 32'd1);
        drive(N, N, 1'b1); tick();
        chk_out("tmo_p1_done", 1'b0, P1, N, 3'd0, N, 1'b0, 1'b1);
        drive(N, N, 1'b0); tick();

        // Reset in the middle of a grant to port 3
        drive(N, P3, 1'b0); tick();
        drive(P3, N, 1'b0); tick();
        drive(N, N, 1'b0);  tick();
        chk_out("rst_pre_grant", 1'b1, N, N, 3'd0, N, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 chk_out("rst_async_drop", 1'b0, N, N, 3'd0, N, 1'b0, 1'b0);
        disp_ack = 1'b1;
        tick();
        chk_out("rst_held", 1'b0, N, N, 3'd0, N, 1'b0, 1'b0);
        disp_ack = 1'b0;
        reset = 1'b1;
        drive(P0, N, 1'b0); tick();
        drive(N, P0, 1'b0); tick();
        drive(N, N, 1'b0);  tick();
        chk_out("rst_after_grant", 1'b1, N, N, 3'd0, N, 1'b0, 1'b1);
        chk("rst_after_port", 32'(disp_port), 32'd0);
        drive(N, N, 1'b1); tick();
        chk_out("rst_after_done", 1'b0, P0, N, 3'd0, N, 1'b0, 1'b1);
        drive(N, N, 1'b0); tick();
        tick();
        chk_out("rst_credit_lost", 1'b0, N, N, 3'd0, N, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_dispense_sched.md
Name: vend_dispense_sched

Overview:
- Shares one chocolate dispenser mechanism among NPORT coin-entry kiosks.
- Keeps a per-port credit balance from one-rupee and two-rupee coin pulses.
- When a port's balance reaches PRICE, a round-robin arbiter grants it the dispenser over a req/ack handshake, then issues the product and change indications to that port.
- Sits between the kiosk coin detectors and the shared dispenser actuator.

Parameters:
- NPORT, 4, number of kiosk requesters (2..8).
- PRICE, 3, product price in rupees.
- MAX_CREDIT, 6, per-port credit ceiling in rupees.
- CW, 3, credit counter width; must satisfy 2^CW > MAX_CREDIT.
- TIMEOUT, 255, cycles to wait for disp_ack before abandoning a grant.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- one_in  input  NPORT  per-port one-rupee coin pulse, one cycle per coin.
- two_in  input  NPORT  per-port two-rupee coin pulse, one cycle per coin.
- disp_req  output  1  dispense request to the shared mechanism.
- disp_port  output  clog2(NPORT)  index of the granted port; valid while disp_req=1.
- disp_ack  input  1  dispenser completed the dispense.
- choco_out  output  NPORT  one-cycle pulse on the port served.
- chng_out  output  NPORT  one-cycle pulse on the port served when change is owed.
- chng_amt  output  CW  change in rupees (credit - PRICE); valid with chng_out.
- coin_rej  output  NPORT  one-cycle pulse when a coin is refused.
- fault  output  1  one-cycle pulse when a grant times out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, all credits=0, RR pointer=0 (port 0 highest priority).
  - Timeout counter=0; every output 0.
- Coin intake, per port, registered and independent of FSM state except as noted:
  - one_in & ~two_in adds 1; two_in & ~one_in adds 2.
  - Both asserted in the same cycle: coin ignored, coin_rej pulses next cycle, credit unchanged.
  - Add that would exceed MAX_CREDIT: refused with coin_rej, credit unchanged; no saturation to a partial value.
  - Port currently granted (GRANT or DONE): all its coins refused with coin_rej.
- Ready: a port is ready when its registered credit >= PRICE.
- Arbitration in IDLE:
  - Search starts at the RR pointer and wraps modulo NPORT; the first ready port wins.
  - Winner is latched into disp_port; next state is GRANT.
  - No ready port: stay in IDLE.
- FSM states:
  - IDLE: described above.
  - GRANT:
    - disp_req=1; disp_port held stable; timeout counter increments each cycle.
    - disp_ack=1 sampled at a clock edge -> DONE.
    - Counter reaches TIMEOUT with no ack -> IDLE: fault pulses one cycle, disp_req drops, the port keeps its credit, and the RR pointer moves to winner+1.
  - DONE (exactly one cycle):
    - disp_req=0; choco_out[winner]=1.
    - If credit > PRICE: chng_out[winner]=1 and chng_amt=credit-PRICE. Otherwise chng_amt=0.
    - At exit, credit[winner] is cleared, the RR pointer moves to winner+1 mod NPORT, the timeout counter is cleared, and the FSM returns to IDLE.
- Latency:
  - A coin edge that makes a port ready -> GRANT entered 2 edges later when the FSM is idle (credit register, then arbitration register).
  - Ack edge -> choco_out high in the following cycle.
- disp_ack outside GRANT is ignored.
- Arithmetic: credit and change are unsigned CW-bit; no wrap is possible because of the MAX_CREDIT check.
- Reset asserted mid-GRANT or mid-DONE: immediate return to IDLE, credits lost, disp_req drops asynchronously, no choco_out or chng_out pulse.
- Simultaneous ready ports are served one per grant in RR order; a port never waits more than NPORT-1 grants.

Test Plan:
- Port 0 receives two_in, then one_in; ack 3 cycles after disp_req -> disp_req=1 with disp_port=0, then choco_out[0] one cycle, chng_out[0]=0, credit 0.
- Port 2 receives two_in twice (credit 4); ack -> choco_out[2] and chng_out[2] pulse together with chng_amt=1.
- Ports 1 and 3 become ready in the same cycle with pointer=0 -> port 1 served first, then port 3, then the pointer is 0 again; repeat with pointer=2 -> port 3 first.
- Port 0 reaches credit 6, then one_in -> coin_rej[0] pulse, credit stays 6. one_in and two_in asserted together on port 1 -> coin_rej[1], no credit change.
- Port 1 ready, disp_ack held 0 for TIMEOUT cycles -> fault pulse, disp_req=0, credit retained; ready port 2 is granted next, then port 1 again.
- reset driven low while in GRANT -> disp_req=0 immediately, busy=0, no choco_out; after release a new 1+2 sequence is served normally.
